// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared mode constants and FSM state type for the serial add/sub datapath
package serial_arith_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/response bundle between a requester (master) and the serial add/sub unit (slave)
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  modport master (output start, mode, a, b, input busy, done, result, carry_out, overflow);
  modport slave (input start, mode, a, b, output busy, done, result, carry_out, overflow);
endinterface

// File: rtl/full_add_sub_cell.sv
// full_add_sub_cell: combinational 1-bit full adder / full subtractor selected by mode
module full_add_sub_cell
  import serial_arith_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);
  assign s = ai ^ bi ^ cin;
  assign cout = mode == MODE_SUB ? (~ai & bi) | (cin & ~(ai ^ bi)) : (ai & bi) | (cin & (ai ^ bi));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, one bit per clock LSB first, registered result and flags
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_sub_if.slave bus
);
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             rmode;
  logic             cin;
  logic             carry_out;
  logic             overflow;
  logic             s;
  logic             cout;
  logic             accept;
  logic             last;
  full_add_sub_cell u_cell (
    .ai  (ra[0]),
    .bi  (rb[0]),
    .cin (cin),
    .mode(rmode),
    .s   (s),
    .cout(cout)
  );
  always_comb begin
    accept = bus.start && state != SHIFT;
    last = state == SHIFT && cnt == CNT_W'(WIDTH - 1);
    state_nxt = accept ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rmode     <= 1'b0;
      cin       <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ra    <= bus.a;
        rb    <= bus.b;
        rmode <= bus.mode;
        cin   <= 1'b0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        ra  <= {s, ra[WIDTH-1:1]};
        rb  <= rb >> 1;
        cin <= cout;
        cnt <= cnt + CNT_W'(1);
      end
      if (last) begin
        result    <= {s, ra[WIDTH-1:1]};
        carry_out <= cout;
        overflow  <= (rmode == MODE_ADD ? ra[0] == rb[0] : ra[0] != rb[0]) && s != ra[0];
      end
    end
  end
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  assign bus.result = result;
  assign bus.carry_out = carry_out;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed self-checking bench for serial_add_sub against an arithmetic model
module tb_serial_add_sub;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  serial_add_sub_if #(.WIDTH(W)) bus ();
  serial_add_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ur = m ? ua - ub : ua + ub;
    int sr = m ? sa - sb : sa + sb;
    logic c = m ? ua < ub : ur > 2 ** W - 1;
    logic v = sr > 2 ** (W - 1) - 1 || sr < -(2 ** (W - 1));
    logic [W-1:0] r = W'(ur);
    return {c, v, r};
  endfunction
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.mode = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.mode = 1'($urandom);
  endtask
  task automatic wait_done(input logic [W+1:0] exp, input string name, input bit scramble, input int inj_at);
    int lat = -1;
    bit bad = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      if (!bus.busy) bad = 1'b1;
      if (scramble) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.mode = 1'($urandom);
      end
      bus.start = i == inj_at;
      if (i == inj_at) begin
        bus.a = 8'd50;
        bus.b = 8'd20;
        bus.mode = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks += 4;
    if (lat != W) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, W);
    end
    if (bad) begin
      failures++;
      $display("FAIL %s busy: dropped before done", name);
    end
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b, want 0", name, bus.busy);
    end
    if ({bus.carry_out, bus.overflow, bus.result} !== exp) begin
      failures++;
      $display("FAIL %s result: got c=%b v=%b r=%h, want c=%b v=%b r=%h", name, bus.carry_out,
               bus.overflow, bus.result, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask
  task automatic check_pulse_end(input logic [W+1:0] exp, input string name);
    @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: got done=%b busy=%b, want 0 0", name, bus.done, bus.busy);
    end
    if ({bus.carry_out, bus.overflow, bus.result} !== exp) begin
      failures++;
      $display("FAIL %s hold: got r=%h, want r=%h", name, bus.result, exp[W-1:0]);
    end
  endtask
  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.carry_out, bus.overflow, bus.result} !== '0) begin
      failures++;
      $display("FAIL reset: got busy=%b done=%b c=%b v=%b r=%h, want all 0", bus.busy, bus.done,
               bus.carry_out, bus.overflow, bus.result);
    end
  endtask
  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'd100, 8'hFF, 8'h7F, 8'd5, 8'h80};
    logic [W-1:0] tb[5] = '{8'd27, 8'h01, 8'h01, 8'd9, 8'h01};
    logic tm[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] te[5] = '{{2'b00, 8'd127}, {2'b10, 8'h00}, {2'b01, 8'h80}, {2'b10, 8'hFC}, {2'b01, 8'h7F}};
    for (int k = 0; k < 5; k++) begin
      launch(ta[k], tb[k], tm[k]);
      wait_done(te[k], $sformatf("directed%0d", k), 1'b0, -1);
      check_pulse_end(te[k], $sformatf("directed%0d", k));
    end
  endtask
  task automatic test_ignore_start();
    launch(8'd3, 8'd4, 1'b0);
    wait_done({2'b00, 8'd7}, "ignore", 1'b0, 3);
    check_pulse_end({2'b00, 8'd7}, "ignore");
    for (int i = 0; i < W + 2; i++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL ignore extra: got done=%b busy=%b at %0d, want 0 0", bus.done, bus.busy, i);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid();
    bit seen = 1'b0;
    launch(8'd3, 8'd4, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid: got done/busy after abort, want none");
    end
    launch(8'd1, 8'd1, 1'b0);
    wait_done({2'b00, 8'd2}, "after_reset", 1'b0, -1);
    check_pulse_end({2'b00, 8'd2}, "after_reset");
  endtask
  task automatic test_back_to_back();
    launch(8'd10, 8'd20, 1'b0);
    wait_done({2'b00, 8'd30}, "b2b_first", 1'b0, -1);
    launch(8'd30, 8'd40, 1'b1);
    checks++;
    if (bus.result !== 8'd30 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got r=%h done=%b busy=%b, want 1e 0 1", bus.result, bus.done, bus.busy);
    end
    wait_done({2'b10, 8'hF6}, "b2b_second", 1'b0, -1);
    check_pulse_end({2'b10, 8'hF6}, "b2b_second");
  endtask
  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a = W'($urandom);
      logic [W-1:0] b = W'($urandom);
      logic m = 1'($urandom);
      logic [W+1:0] e;
      if (k % 8 == 0) a = 8'h80;
      if (k % 8 == 1) b = 8'h7F;
      e = model(a, b, m);
      launch(a, b, m);
      wait_done(e, $sformatf("random%0d %h%s%h", k, a, m ? "-" : "+", b), 1'b1, -1);
      check_pulse_end(e, "random");
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised bit-serial adder/subtractor, the multi-bit, clocked successor of the team's 1-bit half adder / half subtractor cells.
- Accepts two WIDTH-bit operands and a mode bit on a start strobe.
- Processes one bit per clock, LSB first, through a single 1-bit full add/sub cell with a registered carry/borrow.
- Returns the result, carry/borrow and signed overflow with a one-cycle done pulse.
- Used wherever area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (legal range WIDTH >= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A (minuend when subtracting); sampled with start
b  input  WIDTH  operand B (subtrahend when subtracting); sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  sum or difference modulo 2^WIDTH
carry_out  output  1  add: unsigned carry out; sub: borrow out (1 iff a < b unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Single clock domain, one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - FSM goes to IDLE; all outputs and internal registers go to 0.
  - The aborted operation produces no done pulse.
- FSM states:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while count < WIDTH-1.
  - SHIFT -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> SHIFT if start=1, otherwise DONE -> IDLE.
- Accept edge (start=1 in IDLE or DONE):
  - Capture a, b and mode into shift registers.
  - Clear the carry/borrow register and the bit counter.
- start while busy=1 is ignored entirely; operands and operation are unaffected.
- Per SHIFT cycle, the cell consumes LSBs ai, bi and cin:
  - add: s = ai^bi^cin; cout = ai&bi | cin&(ai^bi).
  - sub: d = ai^bi^cin; bout = ~ai&bi | cin&~(ai^bi).
  - s/d shifts into result from the MSB side; the operand registers shift right; cin register updated.
- Latency:
  - busy is high from the edge after the accept edge through the last SHIFT edge (exactly WIDTH cycles).
  - done is high for exactly one cycle starting WIDTH edges after the accept edge; busy=0 during that cycle.
  - Back-to-back: start during the done cycle is accepted, giving throughput of one operation per WIDTH+1 cycles.
- result, carry_out and overflow are registered and updated only when done rises. They hold their values until the next done or reset, and do not show partial values during SHIFT.
- overflow, evaluated on captured operands and final result (M = WIDTH-1):
  - add: a[M]==b[M] && result[M]!=a[M].
  - sub: a[M]!=b[M] && result[M]!=a[M].
- Wrap-around: result is always modulo 2^WIDTH; nothing saturates.
- Input changes on a/b/mode outside the accept edge have no effect.

Decomposition:
- Shared package serial_arith_pkg:
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
  - FSM state enum {IDLE, SHIFT, DONE}.
- One sub-module: full_add_sub_cell (inputs ai, bi, cin, mode; outputs s, cout).
  - Purely combinational 1-bit cell generalising the existing half adder/half subtractor.
  - Instantiated once; the top holds the FSM, counter, shift and flag registers.

Test Plan:
- WIDTH=8, add 100+27 -> done exactly 8 cycles after accept; result=127, carry_out=0, overflow=0.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Sub 5-9 -> result=0xFC, carry_out(borrow)=1, overflow=0; sub 0x80-0x01 -> result=0x7F, borrow=0, overflow=1.
- Start add 3+4; pulse start with sub 50-20 on busy cycle 3 -> ignored; done once, result=7, busy/done timing unchanged.
- Assert rst_n=0 mid-operation (busy cycle 4) -> all outputs 0 immediately, no done; after release, add 1+1 -> result=2 after 8 cycles.
- Back-to-back: start 10+20, then start 30-40 during the done cycle -> result=30 then result=0xF6 with borrow=1; done pulses 9 cycles apart.
